// File: rtl/nasti_lite_read_arbiter.sv
// Round-robin arbiter sharing one NASTI-lite read port (AR + R) between N_MASTER requesters.
// Granted requester indices are queued in AR order so each R beat is steered back to its issuer.
module nasti_lite_read_arbiter #(
   parameter int unsigned N_MASTER        = 2,
   parameter int unsigned ID_WIDTH        = 1,
   parameter int unsigned ADDR_WIDTH      = 8,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned USER_WIDTH      = 1,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic [N_MASTER*ID_WIDTH-1:0]     m_ar_id,
   input  logic [N_MASTER*ADDR_WIDTH-1:0]   m_ar_addr,
   input  logic [N_MASTER*3-1:0]            m_ar_prot,
   input  logic [N_MASTER*4-1:0]            m_ar_qos,
   input  logic [N_MASTER*4-1:0]            m_ar_region,
   input  logic [N_MASTER*USER_WIDTH-1:0]   m_ar_user,
   input  logic [N_MASTER-1:0]              m_ar_valid,
   output logic [N_MASTER-1:0]              m_ar_ready,
   output logic [N_MASTER*ID_WIDTH-1:0]     m_r_id,
   output logic [N_MASTER*DATA_WIDTH-1:0]   m_r_data,
   output logic [N_MASTER*2-1:0]            m_r_resp,
   output logic [N_MASTER*USER_WIDTH-1:0]   m_r_user,
   output logic [N_MASTER-1:0]              m_r_valid,
   input  logic [N_MASTER-1:0]              m_r_ready,
   output logic [ID_WIDTH-1:0]              s_ar_id,
   output logic [ADDR_WIDTH-1:0]            s_ar_addr,
   output logic [2:0]                       s_ar_prot,
   output logic [3:0]                       s_ar_qos,
   output logic [3:0]                       s_ar_region,
   output logic [USER_WIDTH-1:0]            s_ar_user,
   output logic                             s_ar_valid,
   input  logic                             s_ar_ready,
   input  logic [ID_WIDTH-1:0]              s_r_id,
   input  logic [DATA_WIDTH-1:0]            s_r_data,
   input  logic [1:0]                       s_r_resp,
   input  logic [USER_WIDTH-1:0]            s_r_user,
   input  logic                             s_r_valid,
   output logic                             s_r_ready
);
   localparam int unsigned IDX_W = $clog2(N_MASTER);
   localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] rr_ptr, grant_q, grant, cand, head;
   logic [IDX_W-1:0] fifo_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full, empty, ar_req, ar_hs, r_hs;
   int unsigned      idx;

   assign full  = (count == CNT_W'(MAX_OUTSTANDING));
   assign empty = (count == '0);
   assign head  = fifo_mem[rd_ptr];

   always_comb begin
      state_nxt = state;
      grant     = grant_q;
      ar_req    = 1'b0;
      idx       = 0;
      cand      = '0;
      case (state)
         IDLE: begin
            if (!full) begin
               for (int unsigned i = 0; i < N_MASTER; i++) begin
                  idx = 32'(rr_ptr) + i;
                  if (idx >= N_MASTER) idx = idx - N_MASTER;
                  cand = IDX_W'(idx);
                  if (!ar_req && m_ar_valid[cand]) begin
                     ar_req = 1'b1;
                     grant  = cand;
                  end
               end
            end
            if (ar_req && !s_ar_ready) state_nxt = LOCKED;
         end
         LOCKED: begin
            ar_req = m_ar_valid[grant_q];
            if (s_ar_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Requester valids are combinational, so mask them while reset is held.
      if (!rstn) ar_req = 1'b0;
   end

   assign s_ar_valid = ar_req;
   assign ar_hs      = ar_req && s_ar_ready;

   always_comb begin
      s_ar_id     = '0;
      s_ar_addr   = '0;
      s_ar_prot   = '0;
      s_ar_qos    = '0;
      s_ar_region = '0;
      s_ar_user   = '0;
      if (ar_req) begin
         s_ar_id     = m_ar_id[grant*ID_WIDTH +: ID_WIDTH];
         s_ar_addr   = m_ar_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
         s_ar_prot   = m_ar_prot[grant*3 +: 3];
         s_ar_qos    = m_ar_qos[grant*4 +: 4];
         s_ar_region = m_ar_region[grant*4 +: 4];
         s_ar_user   = m_ar_user[grant*USER_WIDTH +: USER_WIDTH];
      end
   end

   always_comb begin
      m_ar_ready = '0;
      m_r_valid  = '0;
      for (int unsigned i = 0; i < N_MASTER; i++) begin
         m_ar_ready[i] = ar_hs && (grant == IDX_W'(i));
         m_r_valid[i]  = !empty && s_r_valid && (head == IDX_W'(i));
      end
   end

   assign s_r_ready = !empty && m_r_ready[head];
   assign r_hs      = s_r_valid && s_r_ready;

   assign m_r_id   = {N_MASTER{s_r_id}};
   assign m_r_data = {N_MASTER{s_r_data}};
   assign m_r_resp = {N_MASTER{s_r_resp}};
   assign m_r_user = {N_MASTER{s_r_user}};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         grant_q <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && ar_req && !s_ar_ready) grant_q <= grant;
         if (ar_hs) begin
            rr_ptr <= (grant == IDX_W'(N_MASTER - 1)) ? '0 : grant + 1'b1;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (r_hs) rd_ptr <= rd_ptr + 1'b1;
         if (ar_hs && !r_hs)      count <= count + 1'b1;
         else if (!ar_hs && r_hs) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (ar_hs) fifo_mem[wr_ptr] <= grant;
   end

   a_locked_valid_held: assert property (@(posedge clk) disable iff (!rstn)
      (state == LOCKED) |-> m_ar_valid[grant_q]);

endmodule

// File: tb/tb_nasti_lite_read_arbiter.sv
// Directed bench for nasti_lite_read_arbiter: a queue-based model of grants and R routing is
// checked every cycle, plus literal expectations taken from hand-worked scenarios.
module tb_nasti_lite_read_arbiter;
   localparam int N = 2, IW = 1, AW = 8, DW = 32, UW = 1, MO = 4;

   logic            clk = 1'b1;
   logic            rstn = 1'b0;
   logic [N*IW-1:0] m_ar_id;
   logic [N*AW-1:0] m_ar_addr;
   logic [N*3-1:0]  m_ar_prot;
   logic [N*4-1:0]  m_ar_qos, m_ar_region;
   logic [N*UW-1:0] m_ar_user;
   logic [N-1:0]    m_ar_valid = '0, m_ar_ready;
   logic [N*IW-1:0] m_r_id;
   logic [N*DW-1:0] m_r_data;
   logic [N*2-1:0]  m_r_resp;
   logic [N*UW-1:0] m_r_user;
   logic [N-1:0]    m_r_valid, m_r_ready = '0;
   logic [IW-1:0]   s_ar_id;
   logic [AW-1:0]   s_ar_addr;
   logic [2:0]      s_ar_prot;
   logic [3:0]      s_ar_qos, s_ar_region;
   logic [UW-1:0]   s_ar_user;
   logic            s_ar_valid, s_ar_ready = 1'b0;
   logic [IW-1:0]   s_r_id = '0;
   logic [DW-1:0]   s_r_data = '0;
   logic [1:0]      s_r_resp = '0;
   logic [UW-1:0]   s_r_user = '0;
   logic            s_r_valid = 1'b0, s_r_ready;

   nasti_lite_read_arbiter #(
      .N_MASTER(N), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .USER_WIDTH(UW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .rstn(rstn),
      .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_prot(m_ar_prot), .m_ar_qos(m_ar_qos),
      .m_ar_region(m_ar_region), .m_ar_user(m_ar_user), .m_ar_valid(m_ar_valid),
      .m_ar_ready(m_ar_ready),
      .m_r_id(m_r_id), .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_user(m_r_user),
      .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
      .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr), .s_ar_prot(s_ar_prot), .s_ar_qos(s_ar_qos),
      .s_ar_region(s_ar_region), .s_ar_user(s_ar_user), .s_ar_valid(s_ar_valid),
      .s_ar_ready(s_ar_ready),
      .s_r_id(s_r_id), .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_user(s_r_user),
      .s_r_valid(s_r_valid), .s_r_ready(s_r_ready)
   );

   always #5 clk = ~clk;

   // Requester 0 and 1 carry distinct AR fields so a wrong slice is visible.
   assign m_ar_id     = 2'b10;
   assign m_ar_addr   = {8'h40, 8'h10};
   assign m_ar_prot   = {3'd6, 3'd1};
   assign m_ar_qos    = {4'hC, 4'h3};
   assign m_ar_region = {4'hA, 4'h5};
   assign m_ar_user   = 2'b10;

   int mq[$];
   int mrr   = 0;
   int mhold = -1;

   function automatic void model_eval(output logic arv, output int g,
                                      output logic [N-1:0] mar, output logic [N-1:0] mrv,
                                      output logic srr);
      arv = 1'b0; g = 0; mar = '0; mrv = '0; srr = 1'b0;
      if (rstn) begin
         if (mhold >= 0) begin
            g   = mhold;
            arv = m_ar_valid[g];
         end else if (mq.size() < MO) begin
            for (int k = 0; k < N; k++) begin
               int c;
               c = (mrr + k) % N;
               if (!arv && m_ar_valid[c]) begin
                  arv = 1'b1;
                  g   = c;
               end
            end
         end
         if (arv && s_ar_ready) mar[g] = 1'b1;
         if (mq.size() > 0) begin
            srr = m_r_ready[mq[0]];
            if (s_r_valid) mrv[mq[0]] = 1'b1;
         end
      end
   endfunction

   always @(posedge clk or negedge rstn) begin
      logic arv, srr;
      int g;
      logic [N-1:0] mar, mrv;
      if (!rstn) begin
         mq.delete();
         mrr   = 0;
         mhold = -1;
      end else begin
         model_eval(arv, g, mar, mrv, srr);
         if ((|mrv) && srr) void'(mq.pop_front());
         if (arv && s_ar_ready) begin
            mq.push_back(g);
            mrr   = (g + 1) % N;
            mhold = -1;
         end else if (arv) begin
            mhold = g;
         end
      end
   end

   int     n_vec = 0, n_err = 0;
   int     lit_arv = -1, lit_mar = -1, lit_mrv = -1, lit_srr = -1;
   longint lit_addr = -1, lit_data = -1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic arv, srr;
      int g;
      logic [N-1:0] mar, mrv;
      model_eval(arv, g, mar, mrv, srr);
      chk("s_ar_valid", 64'(s_ar_valid), 64'(arv));
      chk("m_ar_ready", 64'(m_ar_ready), 64'(mar));
      chk("s_ar_addr", 64'(s_ar_addr), arv ? 64'(m_ar_addr[g*AW +: AW]) : 64'd0);
      chk("s_ar_id", 64'(s_ar_id), arv ? 64'(m_ar_id[g*IW +: IW]) : 64'd0);
      chk("s_ar_prot", 64'(s_ar_prot), arv ? 64'(m_ar_prot[g*3 +: 3]) : 64'd0);
      chk("s_ar_qos", 64'(s_ar_qos), arv ? 64'(m_ar_qos[g*4 +: 4]) : 64'd0);
      chk("s_ar_region", 64'(s_ar_region), arv ? 64'(m_ar_region[g*4 +: 4]) : 64'd0);
      chk("s_ar_user", 64'(s_ar_user), arv ? 64'(m_ar_user[g*UW +: UW]) : 64'd0);
      chk("m_r_valid", 64'(m_r_valid), 64'(mrv));
      chk("s_r_ready", 64'(s_r_ready), 64'(srr));
      if (|mrv) begin
         chk("m_r_data", 64'(m_r_data[mq[0]*DW +: DW]), 64'(s_r_data));
         chk("m_r_id", 64'(m_r_id[mq[0]*IW +: IW]), 64'(s_r_id));
      end
      if (lit_arv >= 0)  chk("lit_s_ar_valid", 64'(s_ar_valid), 64'(lit_arv));
      if (lit_mar >= 0)  chk("lit_m_ar_ready", 64'(m_ar_ready), 64'(lit_mar));
      if (lit_addr >= 0) chk("lit_s_ar_addr", 64'(s_ar_addr), 64'(lit_addr));
      if (lit_mrv >= 0)  chk("lit_m_r_valid", 64'(m_r_valid), 64'(lit_mrv));
      if (lit_srr >= 0)  chk("lit_s_r_ready", 64'(s_r_ready), 64'(lit_srr));
      if (lit_data >= 0) chk("lit_m_r_data1", 64'(m_r_data[DW +: DW]), 64'(lit_data));
   end

   // One cycle: drive inputs, arm literal expectations (-1 = unchecked), advance past posedge.
   task automatic cyc(input logic [1:0] arv_in, input logic sar, input logic srv,
                      input logic [1:0] mrr_in, input logic [31:0] data,
                      input int e_arv, input int e_mar, input longint e_addr,
                      input int e_mrv, input int e_srr, input longint e_data);
      m_ar_valid = arv_in; s_ar_ready = sar; s_r_valid = srv; m_r_ready = mrr_in;
      s_r_data = data; s_r_id = data[0];
      lit_arv = e_arv; lit_mar = e_mar; lit_addr = e_addr;
      lit_mrv = e_mrv; lit_srr = e_srr; lit_data = e_data;
      @(posedge clk);
      #1;
      lit_arv = -1; lit_mar = -1; lit_addr = -1; lit_mrv = -1; lit_srr = -1; lit_data = -1;
   endtask

   initial begin
      // Reset held with every requester input active
      cyc(2'b11, 1, 1, 2'b11, 32'h0,        0, 0, 0,     0, 0, -1);
      rstn = 1'b1;
      // Single requester 1, then its return beat
      cyc(2'b10, 1, 0, 2'b11, 32'h0,        1, 2, 'h40, -1, -1, -1);
      cyc(2'b00, 1, 1, 2'b11, 32'hDEADBEEF, 0, -1, -1,   2, 1, 'hDEADBEEF);
      // Fairness: alternating grants fill the FIFO to 0,1,0,1
      cyc(2'b11, 1, 0, 2'b11, 32'h0,        1, 1, 'h10, -1, -1, -1);
      cyc(2'b11, 1, 0, 2'b11, 32'h0,        1, 2, 'h40, -1, -1, -1);
      cyc(2'b11, 1, 0, 2'b11, 32'h0,        1, 1, 'h10, -1, -1, -1);
      cyc(2'b11, 1, 0, 2'b11, 32'h0,        1, 2, 'h40, -1, -1, -1);
      // FIFO full: fifth AR blocked, still blocked in the pop cycle, accepted after
      cyc(2'b01, 1, 0, 2'b11, 32'h0,        0, 0, 0,    -1, -1, -1);
      cyc(2'b01, 1, 1, 2'b11, 32'h11111111, 0, 0, 0,     1, 1, -1);
      cyc(2'b01, 1, 0, 2'b11, 32'h0,        1, 1, 'h10, -1, -1, -1);
      // R stall on head=1 while requester 0 is ready
      cyc(2'b00, 0, 1, 2'b01, 32'h22222222, 0, -1, -1,   2, 0, -1);
      // Drain in order 1,0,1,0
      cyc(2'b00, 0, 1, 2'b11, 32'h33333333, -1, -1, -1,  2, 1, 'h33333333);
      cyc(2'b00, 0, 1, 2'b11, 32'h44444444, -1, -1, -1,  1, 1, -1);
      cyc(2'b00, 0, 1, 2'b11, 32'h55555555, -1, -1, -1,  2, 1, 'h55555555);
      cyc(2'b00, 0, 1, 2'b11, 32'h66666666, -1, -1, -1,  1, 1, -1);
      // Move rr_ptr back to 0, then backpressure lock on requester 0
      cyc(2'b10, 1, 0, 2'b11, 32'h0,        1, 2, 'h40,  0, 0, -1);
      cyc(2'b11, 0, 1, 2'b11, 32'h77777777, 1, 0, 'h10,  2, 1, -1);
      cyc(2'b11, 0, 0, 2'b11, 32'h0,        1, 0, 'h10, -1, -1, -1);
      cyc(2'b11, 0, 0, 2'b11, 32'h0,        1, 0, 'h10, -1, -1, -1);
      cyc(2'b11, 1, 0, 2'b11, 32'h0,        1, 1, 'h10, -1, -1, -1);
      cyc(2'b11, 1, 0, 2'b11, 32'h0,        1, 2, 'h40, -1, -1, -1);
      cyc(2'b11, 1, 0, 2'b11, 32'h0,        1, 1, 'h10, -1, -1, -1);
      // Reset with three outstanding reads, then restart from rr_ptr 0 with an empty FIFO
      rstn = 1'b0;
      cyc(2'b11, 1, 1, 2'b11, 32'h88888888, 0, 0, 0,     0, 0, -1);
      rstn = 1'b1;
      cyc(2'b11, 1, 1, 2'b11, 32'h99999999, 1, 1, 'h10,  0, 0, -1);
      cyc(2'b00, 0, 0, 2'b00, 32'h0,        0, 0, 0,     0, 0, -1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/nasti_lite_read_arbiter.md
# nasti_lite_read_arbiter

Round-robin arbiter that shares one NASTI-lite read port (AR + R) between N_MASTER NASTI-lite read requesters, such as several nasti_lite_reader instances or lite masters, in front of a single lite slave. It grants AR requests one at a time and records the granted requester index in an in-order routing FIFO. Each returning R beat is steered back to the requester that issued it. The downstream slave must return R beats in AR order, one beat per AR.

## Interface
- N_MASTER, 2: number of requesters (≥2)
- ID_WIDTH, 1: id width, passed through unchanged
- ADDR_WIDTH, 8: address width
- DATA_WIDTH, 32: lite data width (32 or 64)
- USER_WIDTH, 1: user width
- MAX_OUTSTANDING, 4: routing FIFO depth, power of two ≥2
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- m_ar_id/addr/prot/qos/region/user  in  N_MASTER×field width  per-requester AR fields, requester i in slice i
- m_ar_valid  in  N_MASTER  per-requester AR valid
- m_ar_ready  out  N_MASTER  per-requester AR ready
- m_r_id/data/resp/user  out  N_MASTER×field width  per-requester R fields, all slices driven from s_r_*
- m_r_valid  out  N_MASTER  per-requester R valid
- m_r_ready  in  N_MASTER  per-requester R ready
- s_ar_id/addr/prot/qos/region/user  out  field width  shared AR fields
- s_ar_valid  out  1;  s_ar_ready  in  1
- s_r_id/data/resp/user  in  field width  shared R fields
- s_r_valid  in  1;  s_r_ready  out  1

## Operation
- AR state machine has two states, IDLE and LOCKED.
  - IDLE, FIFO not full, any m_ar_valid set: grant goes to the first requester with valid asserted, searching from rr_ptr upward modulo N_MASTER. s_ar_* = granted slice, s_ar_valid=1, m_ar_ready[g]=s_ar_ready.
  - IDLE with s_ar_ready=0 and a grant: latch g into grant_q, go to LOCKED.
  - LOCKED: drive grant_q only; no re-arbitration.
  - LOCKED, handshake: return to IDLE.
- rr_ptr updates only on an AR handshake, to (g+1) mod N_MASTER.
- An AR handshake pushes g into the routing FIFO. The arbiter asserts s_ar_valid only when the FIFO is not full.
  - A push while full cannot occur.
  - A pop in the same cycle as full does not unblock AR until the next cycle.
- R routing uses h = FIFO head.
  - FIFO not empty: m_r_valid[h]=s_r_valid, s_r_ready=m_r_ready[h], all other m_r_valid=0.
  - FIFO empty: s_r_ready=0, all m_r_valid=0.
  - An R handshake pops the FIFO.
- Push and pop in the same cycle leave the count unchanged. FIFO pointers wrap modulo MAX_OUTSTANDING. Count width is log2(MAX_OUTSTANDING)+1.
- m_r_* data fields may be broadcast to all slices. Only the valid bit is steered.
- IDs pass through unmodified. The requester index is never encoded into the ID.
- If the granted requester drops m_ar_valid while LOCKED, that is a protocol violation and the behaviour is undefined. Simulation asserts on it.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, grant_q 0, FIFO empty (count 0).
  - m_ar_ready all 0, m_r_valid all 0, s_ar_valid 0, s_r_ready 0.
  - s_ar_* fields 0 while s_ar_valid=0 in reset.
- AR path has zero latency. m_ar_valid to s_ar_valid is combinational in the same cycle, so the handshake completes in the cycle s_ar_ready is sampled high.
- R path has zero latency. s_r_valid to m_r_valid[h] is combinational.
- Back-to-back ARs from different requesters are accepted every cycle while the FIFO has space.
- The FIFO holds at most MAX_OUTSTANDING in-flight reads. The (MAX_OUTSTANDING+1)-th AR stalls until the first pop has been registered.
- An AR that is visible to the slave keeps s_ar_valid asserted and its fields stable until the handshake, per the LOCKED rule.
- Reset mid-operation: all state clears asynchronously. In-flight reads are discarded, and the system must reset the slave together with the arbiter.

## Test plan
- Single requester: m_ar_valid[1]=1, addr 0x40, s_ar_ready=1 → s_ar_addr=0x40 in the same cycle, m_ar_ready=2'b10. Then s_r_valid with data 0xDEADBEEF → m_r_valid=2'b10, m_r_data[1]=0xDEADBEEF.
- Fairness: both requesters hold valid, s_ar_ready=1 for 4 cycles → grant sequence 0,1,0,1. FIFO contents 0,1,0,1. Returns route in the same order.
- Backpressure lock: both valid, s_ar_ready=0 for 3 cycles after grant to 0 → s_ar_addr stays at requester 0's value, state LOCKED. Raise ready → handshake to 0, rr_ptr=1.
- FIFO full: MAX_OUTSTANDING=4, issue 4 ARs with no R → 5th AR sees s_ar_valid=0. One R handshake → 5th AR is accepted the next cycle.
- R stall: head=1, s_r_valid=1, m_r_ready[1]=0, m_r_ready[0]=1 → s_r_ready=0, no pop, m_r_valid[0]=0.
- Reset mid-burst: rstn low with 3 outstanding → count 0, all valid/ready outputs 0, rr_ptr 0 immediately.
